// File: rtl/sm_para_n_if.sv
// Request/grant bundle for sm_para_n: the master drives requests and clear,
// the slave (the state machine) returns grant and status.
interface sm_para_n_if #(
    parameter int N = 2
);
    logic [N-1:0] i;
    logic         clr;
    logic [N-1:0] o;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    modport master (output i, clr, input o, busy, err, err_code);
    modport slave  (input i, clr, output o, busy, err, err_code);
endinterface

// File: rtl/sm_para_n.sv
// N-channel grant FSM with fixed lowest-index priority, grant timeout and
// illegal all-requests detection; every output is a flop (Moore, glitch-free).
module sm_para_n #(
    parameter int N            = 2,
    parameter int TIMEOUT      = 8,
    parameter int AUTO_RECOVER = 0,
    parameter int ERR_HOLD     = 4
) (
    input  logic         clk,
    input  logic         nrst,
    sm_para_n_if.slave   bus
);
    localparam int OW = $clog2(N);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (ERR_HOLD > 2) ? $clog2(ERR_HOLD) : 1;

    localparam logic [1:0] EC_NONE    = 2'b00;
    localparam logic [1:0] EC_TIMEOUT = 2'b01;
    localparam logic [1:0] EC_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [N-1:0]   o_q, o_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic [OW-1:0]  lowest;
    logic           all_ones;
    logic           owner_req;
    logic           hold_done;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        lowest = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.i[k]) lowest = OW'(k);
        end
    end

    assign all_ones  = &bus.i;
    assign owner_req = bus.i[owner_q];
    assign hold_done = (hold_q == HW'(ERR_HOLD - 1));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        err_code_d = err_code_q;

        if (state_q != ERROR && all_ones) begin
            state_d    = ERROR;
            err_code_d = EC_ILLEGAL;
            hold_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|bus.i) begin
                        state_d = GRANT;
                        owner_d = lowest;
                        cnt_d   = '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state_d = RELEASE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d    = ERROR;
                        err_code_d = EC_TIMEOUT;
                        hold_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    state_d = IDLE;
                end
                ERROR: begin
                    if (bus.clr || (AUTO_RECOVER != 0 && hold_done)) begin
                        state_d    = IDLE;
                        err_code_d = EC_NONE;
                    end else if (!hold_done) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so they land in flops together
    // with it, giving the same timing as a decode of the state register.
    always_comb begin
        o_d = '0;
        if (state_d == GRANT) o_d[owner_d] = 1'b1;
        busy_d = (state_d == GRANT) || (state_d == RELEASE);
        err_d  = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            err_code_q <= EC_NONE;
            o_q        <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            err_code_q <= err_code_d;
            o_q        <= o_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.o        = o_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
endmodule
